bcd_seg_scan: RTL
=================

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50_000, giving CLK cycles per digit dwell; legal range 2..2^26.
REQ-002 SHALL have port CLK  input  1  system clock; all state is on the rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port BCD_In  input  8  packed two-digit BCD: [7:4] high digit, [3:0] low digit; may change on any CLK edge, including from a divided clock domain.
REQ-005 SHALL have port Seg  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.
REQ-006 SHALL have port Dig  output  2  active-low digit enables: 2'b10 = low digit, 2'b01 = high digit.
REQ-007 SHALL have port Err  output  1  high while either held nibble is greater than 9.
REQ-008 SHALL have port Upd  output  1  one-cycle pulse when the held value changes.

Function
REQ-009 SHALL sample BCD_In into stage register r1 on every edge and copy r1 into r2 on every edge.
REQ-010 SHALL load held register Disp from r2 only when r1 == r2 and r2 != Disp; a value stable at BCD_In before edge k is in Disp after edge k+2.
REQ-011 SHALL assert Upd for exactly the cycle after each Disp load; a single-cycle BCD_In glitch produces no load and no Upd.
REQ-012 SHALL run a scan counter from 0 to SCAN_DIV-1, wrapping to 0; on wrap the digit select toggles between low and high.
REQ-013 SHALL decode the selected Disp nibble: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex); nibbles A-F SHALL show 'E' = 86; dp always 1.
REQ-014 SHALL register Seg and Dig from the next-state digit select and next-state Disp, so Seg always matches the digit enabled by Dig with no lag cycle.
REQ-015 SHALL register Err from next-state Disp, so Err changes on the same edge that Disp changes.
REQ-016 SHALL, when a Disp load and a digit toggle occur on the same edge, present the new digit decoded from the new Disp on that edge.
REQ-017 SHALL hold Dig one-hot active-low at all times; 2'b00 and 2'b11 are never driven.

Reset
REQ-018 SHALL, while RSTn is low, immediately force r1=r2=Disp=00, scan counter=0, select=low, Dig=2'b10, Seg=C0, Err=0, Upd=0, regardless of CLK.
REQ-019 SHALL resume at the first CLK edge after RSTn rises; reset asserted mid-dwell or mid-load discards the pending sample.

Configuration
REQ-020 SHALL support macro BCD_SEG_LZB_EN: when defined, a high digit of 0 is blanked (Seg=FF while Dig=2'b01); when undefined, a high digit of 0 shows C0. The low digit is never blanked.

Verification
REQ-021 SHALL cover: SCAN_DIV=4, BCD_In=05 held through reset release -> Upd pulse after edge 3; low digit Seg=92; high digit Seg=C0, or FF with BCD_SEG_LZB_EN.
REQ-022 SHALL cover: SCAN_DIV=4, BCD_In steady -> Dig sequence 10,10,10,10,01,01,01,01,10 across consecutive edges.
REQ-023 SHALL cover: Disp=16; BCD_In=17 for one cycle, then 16 -> no Upd, Disp and Seg unchanged.
REQ-024 SHALL cover: BCD_In=2A -> low digit Seg=86, Err=1 on the load edge; then BCD_In=28 -> Err=0, Seg low=80, high=A4.
REQ-025 SHALL cover: count sequence 27,28,05 at one change per 8 cycles -> three Upd pulses; Disp=05 after the wrap.
REQ-026 SHALL cover: RSTn pulsed low mid-dwell with Disp=19 -> Seg=C0, Dig=10, Err=0, Upd=0 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver with two-stage input debounce/synchroniser.
// Optional leading-zero blanking of the high digit via BCD_SEG_LZB_EN.
module bcd_seg_scan #(
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] BCD_In,
  output logic [7:0] Seg,
  output logic [1:0] Dig,
  output logic       Err,
  output logic       Upd
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [7:0]    r1, r2, disp, disp_nxt;
  logic [CW-1:0] cnt;
  logic          sel, sel_nxt, wrap, ld;
  logic [3:0]    nib;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 8'hC0;
      4'd1:    dec7 = 8'hF9;
      4'd2:    dec7 = 8'hA4;
      4'd3:    dec7 = 8'hB0;
      4'd4:    dec7 = 8'h99;
      4'd5:    dec7 = 8'h92;
      4'd6:    dec7 = 8'h82;
      4'd7:    dec7 = 8'hF8;
      4'd8:    dec7 = 8'h80;
      4'd9:    dec7 = 8'h90;
      default: dec7 = 8'h86;
    endcase
  endfunction

  // Outputs are decoded from next-state values so Seg/Dig/Err never lag Disp or select.
  always_comb begin
    ld       = (r1 == r2) && (r2 != disp);
    disp_nxt = ld ? r2 : disp;
    wrap     = (cnt == CNT_LAST);
    sel_nxt  = sel ^ wrap;
    nib      = sel_nxt ? disp_nxt[7:4] : disp_nxt[3:0];
    seg_nxt  = dec7(nib);
`ifdef BCD_SEG_LZB_EN
    if (sel_nxt && (disp_nxt[7:4] == 4'd0))
      seg_nxt = 8'hFF;
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r1   <= 8'h00;
      r2   <= 8'h00;
      disp <= 8'h00;
      cnt  <= '0;
      sel  <= 1'b0;
      Seg  <= 8'hC0;
      Dig  <= 2'b10;
      Err  <= 1'b0;
      Upd  <= 1'b0;
    end else begin
      r1   <= BCD_In;
      r2   <= r1;
      disp <= disp_nxt;
      cnt  <= wrap ? '0 : cnt + CW'(1);
      sel  <= sel_nxt;
      Seg  <= seg_nxt;
      Dig  <= sel_nxt ? 2'b01 : 2'b10;
      Err  <= (disp_nxt[7:4] > 4'd9) || (disp_nxt[3:0] > 4'd9);
      Upd  <= ld;
    end
  end

endmodule
